cache_ram_sync_param: RTL
=========================

Name: cache_ram_sync_param

Overview:
Parametrised successor to the fixed 16-entry, 256-bit cache data RAM: configurable depth and width, per-byte write enables, and a registered read port.
Adds per-entry valid bits with hit reporting, a read-enable/read-valid handshake, and a sequenced flush engine that zeroes the array one entry per cycle.
Sits under the L1 instruction/data cache controllers as the line storage. Tag comparison stays in the controller.

Parameters:
P_ENTRY_N, 16, number of entries. Must be a power of two, at least 2.
P_ADDR_W, 4, address width. Must satisfy 2**P_ADDR_W == P_ENTRY_N.
P_DATA_W, 256, line width in bits. Must be a multiple of 8. Byte-enable width is P_DATA_W/8.

Ports:
iCLOCK  in  1  clock; all state updates on the rising edge
inRESET  in  1  asynchronous, active-low reset
iFLUSH_REQ  in  1  pulse: start invalidate-and-zero sweep
oFLUSH_BUSY  out  1  high while the sweep runs
iWR_EN  in  1  write strobe
iWR_ADDR  in  P_ADDR_W  write entry index
iWR_BYTEENA  in  P_DATA_W/8  per-byte write enable; bit n covers data[8n+7:8n]
iWR_DATA  in  P_DATA_W  write data
iRD_EN  in  1  read strobe
iRD_ADDR  in  P_ADDR_W  read entry index
oRD_VALID  out  1  oRD_DATA/oRD_HIT updated this cycle, one-cycle pulse
oRD_HIT  out  1  valid bit of the entry that was read
oRD_DATA  out  P_DATA_W  registered read data

Behaviour:
- Reset (inRESET=0, asynchronous):
  - all valid bits = 0, FSM = IDLE, sweep counter = 0
  - oFLUSH_BUSY=0, oRD_VALID=0, oRD_HIT=0, oRD_DATA=0
  - The data array is not reset.
- Write (IDLE only): on iWR_EN=1, each byte lane with its byteena bit set takes iWR_DATA; other lanes keep their old value.
  - If any byteena bit is set, valid[iWR_ADDR] is set to 1.
  - Byteena all zero: no array or valid change.
- Read (IDLE only): iRD_EN=1 at edge N gives, after edge N:
  - oRD_VALID=1
  - oRD_DATA = mem[iRD_ADDR]
  - oRD_HIT = valid[iRD_ADDR]
  - Latency is exactly 1 cycle.
  - When iRD_EN=0: oRD_VALID=0 next cycle; oRD_DATA and oRD_HIT hold their previous values.
- Reads and writes to different addresses in the same cycle are independent.
- Same-address read and write in the same cycle: see Optional Feature.
- FSM states:
  - IDLE: iFLUSH_REQ=1 -> SWEEP, counter=0, oFLUSH_BUSY=1 from the next cycle.
  - SWEEP: each cycle writes mem[counter]=0 and valid[counter]=0, then increments counter. When counter == P_ENTRY_N-1, the last entry is cleared -> DONE.
  - DONE: one cycle, oFLUSH_BUSY still 1 -> IDLE, oFLUSH_BUSY=0.
  - A sweep takes P_ENTRY_N+1 busy cycles.
- While not IDLE:
  - iWR_EN is ignored (write dropped, no queueing).
  - iRD_EN is ignored (oRD_VALID stays 0).
  - iFLUSH_REQ is ignored.
- iFLUSH_REQ together with iWR_EN/iRD_EN in IDLE: the access is performed in that cycle and the flush starts next cycle. The flush clears the written entry later.
- Counter wraps naturally at P_ADDR_W bits. No overflow state.
- Reset asserted mid-sweep: FSM returns to IDLE immediately and all valid bits are cleared. The data array may be partially zeroed; this is legal because valid=0.

Optional Feature:
Macro CACHE_RAM_WR_BYPASS_EN. Applies when, in IDLE, iRD_EN and iWR_EN are both 1 with iRD_ADDR == iWR_ADDR.
- Defined (write-first):
  - oRD_DATA is the merged value: new bytes where byteena is set, old bytes elsewhere.
  - oRD_HIT = old valid OR (|iWR_BYTEENA).
- Undefined (read-first):
  - oRD_DATA is the pre-write contents.
  - oRD_HIT is the pre-write valid bit.
- The array contents after the edge are identical in both builds.

Test Plan:
- Reset release, then read addr 3 -> oRD_VALID=1 one cycle later, oRD_HIT=0, oRD_DATA=array contents.
- Write addr 5, all byteena=1, data = 256'h0123...EF pattern; next cycle read addr 5 -> oRD_HIT=1, oRD_DATA = that pattern.
- Byte-lane merge on addr 5: write byteena=32'h0000_0001, data=all 0xFF; then read -> byte 0 = 0xFF, bytes 1..31 unchanged. Write byteena=0 to addr 6, read -> oRD_HIT=0.
- Same-cycle read/write addr 7 (old = all 0xAA, new = all 0x55, byteena=32'h0000_FFFF):
  - with macro: low 16 bytes 0x55, high 16 bytes 0xAA, oRD_HIT=1
  - without macro: all 0xAA, old hit
- Fill entries 0..15, pulse iFLUSH_REQ -> oFLUSH_BUSY high exactly 17 cycles. A write to addr 2 issued mid-sweep is dropped. After the sweep, reads of all 16 entries -> oRD_HIT=0, oRD_DATA=0.
- Assert inRESET at sweep cycle 6 -> oFLUSH_BUSY=0 immediately, all hits 0 afterward. A new iFLUSH_REQ after reset completes a full sweep.

Source files
------------

// File: rtl/cache_ram_sync_param.sv
// Parametrised cache line RAM: byte-enable writes, registered reads, valid bits, flush sweep.
// Define CACHE_RAM_WR_BYPASS_EN for write-first same-address read/write; default is read-first.
module cache_ram_sync_param #(
  parameter int P_ENTRY_N = 16,
  parameter int P_ADDR_W  = 4,
  parameter int P_DATA_W  = 256
) (
  input  logic                  iCLOCK,
  input  logic                  inRESET,
  input  logic                  iFLUSH_REQ,
  output logic                  oFLUSH_BUSY,
  input  logic                  iWR_EN,
  input  logic [P_ADDR_W-1:0]   iWR_ADDR,
  input  logic [P_DATA_W/8-1:0] iWR_BYTEENA,
  input  logic [P_DATA_W-1:0]   iWR_DATA,
  input  logic                  iRD_EN,
  input  logic [P_ADDR_W-1:0]   iRD_ADDR,
  output logic                  oRD_VALID,
  output logic                  oRD_HIT,
  output logic [P_DATA_W-1:0]   oRD_DATA
);

  localparam int BE_W = P_DATA_W / 8;
  localparam logic [P_ADDR_W-1:0] LAST = P_ADDR_W'(P_ENTRY_N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_t;

  state_t                state;
  logic [P_ADDR_W-1:0]   cnt;
  logic [P_ENTRY_N-1:0]  valid;
  logic [P_DATA_W-1:0]   mem [P_ENTRY_N];

  logic                  idle;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [P_DATA_W-1:0]   wr_merge;
  logic [P_DATA_W-1:0]   rd_data_nxt;
  logic                  rd_hit_nxt;

  assign idle    = (state == S_IDLE);
  assign wr_fire = idle && iWR_EN && (|iWR_BYTEENA);
  assign rd_fire = idle && iRD_EN;

  always_comb begin
    wr_merge = mem[iWR_ADDR];
    for (int b = 0; b < BE_W; b++) begin
      if (iWR_BYTEENA[b]) begin
        wr_merge[8*b +: 8] = iWR_DATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_data_nxt = mem[iRD_ADDR];
    rd_hit_nxt  = valid[iRD_ADDR];
`ifdef CACHE_RAM_WR_BYPASS_EN
    if (wr_fire && (iWR_ADDR == iRD_ADDR)) begin
      rd_data_nxt = wr_merge;
      rd_hit_nxt  = 1'b1;
    end
`endif
  end

  // Line storage has no reset; stale data is masked by the valid bits.
  always_ff @(posedge iCLOCK) begin
    if (state == S_SWEEP) begin
      mem[cnt] <= '0;
    end else if (wr_fire) begin
      mem[iWR_ADDR] <= wr_merge;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state       <= S_IDLE;
      cnt         <= '0;
      valid       <= '0;
      oFLUSH_BUSY <= 1'b0;
      oRD_VALID   <= 1'b0;
      oRD_HIT     <= 1'b0;
      oRD_DATA    <= '0;
    end else begin
      oRD_VALID <= rd_fire;
      if (rd_fire) begin
        oRD_DATA <= rd_data_nxt;
        oRD_HIT  <= rd_hit_nxt;
      end
      unique case (state)
        S_IDLE: begin
          if (wr_fire) begin
            valid[iWR_ADDR] <= 1'b1;
          end
          if (iFLUSH_REQ) begin
            state       <= S_SWEEP;
            cnt         <= '0;
            oFLUSH_BUSY <= 1'b1;
          end
        end
        S_SWEEP: begin
          valid[cnt] <= 1'b0;
          cnt        <= cnt + P_ADDR_W'(1);
          if (cnt == LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          oFLUSH_BUSY <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
